// File: rtl/cv32e40p_voter_pkg.sv
// Shared types for the TMR voter/monitor: replica count, replica index type,
// report FSM states and a lowest-set-bit helper.
package cv32e40p_voter_pkg;

    localparam int NUM_REPLICAS = 3;

    typedef logic [1:0] replica_idx_t;

    typedef enum logic {IDLE, REPORT} report_state_e;

    function automatic replica_idx_t lowest_set(input logic [NUM_REPLICAS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_REPLICAS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = replica_idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/cv32e40p_voter_monitor_if.sv
// Fault-report handshake between the voter monitor (master) and the
// fault-management unit (slave).
interface cv32e40p_voter_monitor_if;
    import cv32e40p_voter_pkg::*;

    logic         report_valid;
    replica_idx_t report_id;
    logic         report_ready;

    modport master (output report_valid, output report_id, input report_ready);
    modport slave  (input report_valid, input report_id, output report_ready);
endinterface

// File: rtl/cv32e40p_voter_replica_mon.sv
// Per-replica fault history: saturating mismatch counter, consecutive-mismatch
// run length, sticky permanent-fault flag and pending-report flag.
module cv32e40p_voter_replica_mon #(
    parameter int CNT_W       = 8,
    parameter int PERM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             mismatch,
    input  logic             ack,
    output logic [CNT_W-1:0] cnt,
    output logic             perm_fault,
    output logic             pend
);
    localparam int RUN_W = $clog2(PERM_THRESH + 1);
    localparam logic [RUN_W-1:0] THRESH = RUN_W'(PERM_THRESH);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             perm_fault_reg, pend_reg;
    logic             new_fault;

    always_comb begin
        cnt_next = cnt_reg;
        run_next = run_reg;
        if (en) begin
            if (mismatch) begin
                if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
                if (run_reg != THRESH)        run_next = run_reg + 1'b1;
            end else begin
                run_next = '0;
            end
        end
    end

    // A replica already declared faulty never re-raises a report.
    assign new_fault = en && (run_next == THRESH) && !perm_fault_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            run_reg        <= '0;
            perm_fault_reg <= 1'b0;
            pend_reg       <= 1'b0;
        end else if (clear) begin
            cnt_reg        <= '0;
            run_reg        <= '0;
            perm_fault_reg <= 1'b0;
            pend_reg       <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            run_reg <= run_next;
            if (new_fault) perm_fault_reg <= 1'b1;
            if (new_fault)     pend_reg <= 1'b1;
            else if (ack)      pend_reg <= 1'b0;
        end
    end

    assign cnt        = cnt_reg;
    assign perm_fault = perm_fault_reg;
    assign pend       = pend_reg;
endmodule

// File: rtl/cv32e40p_voter_monitor.sv
// TMR voter with fault-history tracking and one-shot permanent-fault reports.
// Define CV32E40P_VOTER_OUTREG_EN to register the vote outputs (1-cycle latency).
module cv32e40p_voter_monitor
    import cv32e40p_voter_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int CNT_W       = 8,
    parameter int PERM_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic [LEN-1:0]            in_1_i,
    input  logic [LEN-1:0]            in_2_i,
    input  logic [LEN-1:0]            in_3_i,
    output logic [LEN-1:0]            voted_o,
    output logic                      error_correct_o,
    output logic                      error_detected_o,
    output logic [2:0]                mismatch_o,
    output logic [3*CNT_W-1:0]        err_cnt_o,
    output logic [2:0]                perm_fault_o,
    cv32e40p_voter_monitor_if.master  rpt
);
    logic [NUM_REPLICAS-1:0][LEN-1:0] words;
    logic [NUM_REPLICAS-1:0]          healthy, pend_vec, ack_vec, perm_vec;
    logic [LEN-1:0]                   voted_next;
    logic                             correct_next, detected_next;
    logic [2:0]                       mismatch_next;
    replica_idx_t                     lo_idx, hi_idx;

    assign words   = {in_3_i, in_2_i, in_1_i};
    assign healthy = ~perm_vec;
    assign lo_idx  = lowest_set(healthy);
    assign hi_idx  = healthy[2] ? 2'd2 : 2'd1;

    always_comb begin
        voted_next    = words[0];
        correct_next  = 1'b0;
        detected_next = 1'b0;
        mismatch_next = 3'b000;
        case (healthy)
            3'b111: begin
                if (words[0] == words[1] && words[1] == words[2]) begin
                    voted_next = words[0];
                end else if (words[0] == words[1]) begin
                    correct_next  = 1'b1;
                    mismatch_next = 3'b100;
                end else if (words[0] == words[2]) begin
                    correct_next  = 1'b1;
                    mismatch_next = 3'b010;
                end else if (words[1] == words[2]) begin
                    voted_next    = words[1];
                    correct_next  = 1'b1;
                    mismatch_next = 3'b001;
                end else begin
                    detected_next = 1'b1;
                    mismatch_next = 3'b111;
                end
            end
            3'b011, 3'b101, 3'b110: begin
                voted_next = words[lo_idx];
                if (words[lo_idx] != words[hi_idx]) begin
                    detected_next = 1'b1;
                    mismatch_next = healthy;
                end
            end
            default: begin
                // No majority possible with one or zero trusted replicas.
                detected_next = 1'b1;
                if (healthy != 3'b000) voted_next = words[lo_idx];
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REPLICAS; gi++) begin : g_mon
            cv32e40p_voter_replica_mon #(
                .CNT_W      (CNT_W),
                .PERM_THRESH(PERM_THRESH)
            ) u_mon (
                .clk       (clk),
                .rst       (rst),
                .en        (en_i),
                .clear     (clear_i),
                .mismatch  (mismatch_next[gi]),
                .ack       (ack_vec[gi]),
                .cnt       (err_cnt_o[gi*CNT_W +: CNT_W]),
                .perm_fault(perm_vec[gi]),
                .pend      (pend_vec[gi])
            );
        end
    endgenerate

    assign perm_fault_o = perm_vec;

    report_state_e state_reg, state_next;
    replica_idx_t  id_reg, id_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            id_reg    <= '0;
        end else if (clear_i) begin
            state_reg <= IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (pend_vec != '0) begin
                    state_next = REPORT;
                    id_next    = lowest_set(pend_vec);
                end
            end
            REPORT: begin
                if (rpt.report_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rpt.report_valid = (state_reg == REPORT);
        rpt.report_id    = id_reg;
        ack_vec          = '0;
        if (rpt.report_valid && rpt.report_ready) ack_vec[id_reg] = 1'b1;
    end

`ifdef CV32E40P_VOTER_OUTREG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_o          <= '0;
            error_correct_o  <= 1'b0;
            error_detected_o <= 1'b0;
            mismatch_o       <= 3'b000;
        end else begin
            voted_o          <= voted_next;
            error_correct_o  <= correct_next;
            error_detected_o <= detected_next;
            mismatch_o       <= mismatch_next;
        end
    end
`else
    // Forced low during reset so every output reads zero while rst is held.
    assign voted_o          = rst ? '0 : voted_next;
    assign error_correct_o  = rst ? 1'b0 : correct_next;
    assign error_detected_o = rst ? 1'b0 : detected_next;
    assign mismatch_o       = rst ? 3'b000 : mismatch_next;
`endif
endmodule

// File: tb/tb_cv32e40p_voter_monitor.sv
// Randomised and directed bench for cv32e40p_voter_monitor against a
// behavioural model; a second instance with CNT_W=2 checks counter saturation.
module tb_cv32e40p_voter_monitor;
    import cv32e40p_voter_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst, en, clr, rdy;
    logic [31:0] in1, in2, in3;

    logic [31:0] voted_a, voted_b;
    logic        corr_a, corr_b, det_a, det_b;
    logic [2:0]  mm_a, mm_b, perm_a, perm_b;
    logic [23:0] cnt_a;
    logic [5:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    int          m_cnt[3], m_cnt2[3], m_run[3];
    bit          m_perm[3], m_pend[3];
    bit          m_active;
    int          m_id;
    logic [31:0] r_voted;
    logic        r_corr, r_det;
    logic [2:0]  r_mm;

    always #5 clk = ~clk;

    cv32e40p_voter_monitor_if rpt_a ();
    cv32e40p_voter_monitor_if rpt_b ();
    assign rpt_a.report_ready = rdy;
    assign rpt_b.report_ready = rdy;

    cv32e40p_voter_monitor #(.LEN(32), .CNT_W(8), .PERM_THRESH(T)) dut_a (
        .clk(clk), .rst(rst), .en_i(en), .clear_i(clr),
        .in_1_i(in1), .in_2_i(in2), .in_3_i(in3),
        .voted_o(voted_a), .error_correct_o(corr_a), .error_detected_o(det_a),
        .mismatch_o(mm_a), .err_cnt_o(cnt_a), .perm_fault_o(perm_a), .rpt(rpt_a));

    cv32e40p_voter_monitor #(.LEN(32), .CNT_W(2), .PERM_THRESH(T)) dut_b (
        .clk(clk), .rst(rst), .en_i(en), .clear_i(clr),
        .in_1_i(in1), .in_2_i(in2), .in_3_i(in3),
        .voted_o(voted_b), .error_correct_o(corr_b), .error_detected_o(det_b),
        .mismatch_o(mm_b), .err_cnt_o(cnt_b), .perm_fault_o(perm_b), .rpt(rpt_b));

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Vote from first principles: find a value held by at least two healthy replicas.
    function automatic void model_vote(output logic [31:0] v, output logic c,
                                       output logic d, output logic [2:0] m);
        logic [31:0] w[3];
        int h[$];
        int same;
        bit found;
        logic [31:0] maj;
        w = '{in1, in2, in3};
        for (int k = 0; k < 3; k++) if (!m_perm[k]) h.push_back(k);
        v = in1; c = 1'b0; d = 1'b0; m = 3'b000;
        found = 0; maj = '0;
        if (h.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                same = 0;
                for (int j = 0; j < 3; j++) if (w[j] == w[k]) same++;
                if (!found && same >= 2) begin found = 1; maj = w[k]; end
            end
            if (found) begin
                v = maj;
                for (int k = 0; k < 3; k++) m[k] = (w[k] != maj);
                c = (m != 3'b000);
            end else begin
                d = 1'b1; m = 3'b111;
            end
        end else if (h.size() == 2) begin
            v = w[h[0]];
            if (w[h[0]] != w[h[1]]) begin
                d = 1'b1; m[h[0]] = 1'b1; m[h[1]] = 1'b1;
            end
        end else begin
            d = 1'b1;
            if (h.size() == 1) v = w[h[0]];
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_cnt2[k] = 0; m_run[k] = 0; m_perm[k] = 0; m_pend[k] = 0;
        end
        m_active = 0; m_id = 0;
        r_voted = '0; r_corr = 1'b0; r_det = 1'b0; r_mm = 3'b000;
    endfunction

    function automatic void model_update(input logic [31:0] v, input logic c,
                                         input logic d, input logic [2:0] m);
        bit any_old;
        int first;
        r_voted = v; r_corr = c; r_det = d; r_mm = m;
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0; m_cnt2[k] = 0; m_run[k] = 0; m_perm[k] = 0; m_pend[k] = 0;
            end
            m_active = 0; m_id = 0;
            return;
        end
        any_old = 0; first = 0;
        for (int k = 2; k >= 0; k--) if (m_pend[k]) begin any_old = 1; first = k; end
        if (m_active && rdy) begin
            m_pend[m_id] = 0; m_active = 0;
        end else if (!m_active && any_old) begin
            m_active = 1; m_id = first;
        end
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                if (m[k]) begin
                    if (m_cnt[k] < 255) m_cnt[k]++;
                    if (m_cnt2[k] < 3) m_cnt2[k]++;
                    if (m_run[k] < T) m_run[k]++;
                end else begin
                    m_run[k] = 0;
                end
                if (m_run[k] == T && !m_perm[k]) begin m_perm[k] = 1; m_pend[k] = 1; end
            end
        end
    endfunction

    task automatic step();
        logic [31:0] v;
        logic c, d;
        logic [2:0] m;
        @(negedge clk);
        model_vote(v, c, d, m);
`ifdef CV32E40P_VOTER_OUTREG_EN
        chk("voted", voted_a, r_voted);
        chk("correct", corr_a, r_corr);
        chk("detected", det_a, r_det);
        chk("mismatch", mm_a, r_mm);
`else
        chk("voted", voted_a, v);
        chk("correct", corr_a, c);
        chk("detected", det_a, d);
        chk("mismatch", mm_a, m);
`endif
        chk("err_cnt", cnt_a, {m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]});
        chk("err_cnt_w2", cnt_b, {m_cnt2[2][1:0], m_cnt2[1][1:0], m_cnt2[0][1:0]});
        chk("perm_fault", perm_a, {m_perm[2], m_perm[1], m_perm[0]});
        chk("perm_fault_w2", perm_b, {m_perm[2], m_perm[1], m_perm[0]});
        chk("report_valid", rpt_a.report_valid, m_active);
        chk("report_valid_w2", rpt_b.report_valid, m_active);
        if (m_active) chk("report_id", rpt_a.report_id, m_id[1:0]);
        @(posedge clk);
        model_update(v, c, d, m);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic e, input logic cl, input logic r);
        in1 = a; in2 = b; in3 = c; en = e; clr = cl; rdy = r;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_voted", voted_a, 0);
        chk("rst_correct", corr_a, 0);
        chk("rst_detected", det_a, 0);
        chk("rst_mismatch", mm_a, 0);
        chk("rst_err_cnt", cnt_a, 0);
        chk("rst_perm", perm_a, 0);
        chk("rst_valid", rpt_a.report_valid, 0);
        chk("rst_id", rpt_a.report_id, 0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] base);
        if ($urandom_range(0, 99) < 75) return base;
        return base ^ (32'h1 << $urandom_range(0, 1));
    endfunction

    initial begin
        logic [31:0] base;
        rst = 1'b0; en = 1'b0; clr = 1'b0; rdy = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        #2 do_reset();

        // Clean agreement.
        for (int i = 0; i < 10; i++) drive(32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 1, 0, 0);
        chk("agree_cnt", cnt_a, 0);

        // Transient disagreement on replica 2, below threshold.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("transient_cnt1", cnt_a[15:8], 3);
        chk("transient_perm", perm_a, 0);

        // Replica 3 becomes permanently faulty; report held with ready low.
        for (int i = 0; i < 4; i++) drive(0, 0, 32'hFF, 1, 0, 0);
        chk("perm3", perm_a, 3'b100);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0, 0);
        chk("rep3_valid", rpt_a.report_valid, 1);
        chk("rep3_id", rpt_a.report_id, 2);
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 0);
        chk("rep3_done", rpt_a.report_valid, 0);

        // Two healthy replicas disagree.
        drive(5, 7, 9, 1, 0, 0);
        drive(5, 5, 9, 1, 0, 0);

        // Replicas 1 and 2 fault on the same edge; two reports in index order.
        for (int i = 0; i < 4; i++) drive(1, 2, 0, 1, 0, 1);
        chk("perm_all", perm_a, 3'b111);
        for (int i = 0; i < 8; i++) drive(1, 2, 0, 1, 0, 1);

        // Clear withdraws an outstanding report.
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 3, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("pre_clear_valid", rpt_a.report_valid, 1);
        drive(0, 0, 0, 1, 1, 0);
        chk("clear_valid", rpt_a.report_valid, 0);
        chk("clear_cnt", cnt_a, 0);
        chk("clear_perm", perm_a, 0);

        // Six mismatches on replica 1 without reaching threshold.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0);
            drive(0, 0, 0, 1, 0, 0);
        end
        chk("sat_w8", cnt_a[7:0], 6);
        chk("sat_w2", cnt_b[1:0], 3);
        drive(1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-sequence.
        for (int i = 0; i < 3; i++) drive(0, 9, 9, 1, 0, 0);
        @(negedge clk);
        #2 do_reset();

        for (int c = 0; c < 400; c++) begin
            base = $urandom;
            if (c == 200) begin
                @(negedge clk);
                #2 do_reset();
            end
            drive(pick(base), pick(base), pick(base),
                  $urandom_range(0, 99) < 85,
                  ($urandom_range(0, 99) < 3) || (c % 80 == 79),
                  $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
